// File: rtl/uart_test_pkg.sv
// uart_test_pkg: shared definitions for the UART echo tester.
//   state_t      - tester FSM encoding (IDLE=0, SEND=1, WAIT=2, GAP=3, DONE=4)
//   LFSR_TAPS    - tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of the shift reg)
//   LFSR_SEED / CNT_SEED - seeds for the two pattern flavours
//   PATTERN_SEED - seed of the flavour selected by ECHO_TESTER_LFSR_EN
//   lfsr_next()  - one Fibonacci LFSR step (shift left, feedback into bit 0)
package uart_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] CNT_SEED  = 8'h00;

`ifdef ECHO_TESTER_LFSR_EN
    localparam logic [7:0] PATTERN_SEED = LFSR_SEED;
`else
    localparam logic [7:0] PATTERN_SEED = CNT_SEED;
`endif

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/echo_pattern_gen.sv
// echo_pattern_gen: byte pattern source for the echo tester.
// Macro ECHO_TESTER_LFSR_EN selects an 8-bit Fibonacci LFSR seeded to 8'h01;
// otherwise an incrementing counter from 8'h00 that wraps at 8'hFF.
// Ports:
//   sys_clk, sys_rst_n - clock, async active-low reset (resets to the seed)
//   load               - reload the seed (has priority over advance)
//   advance            - step to the next pattern byte
//   byte_out           - current pattern byte
module echo_pattern_gen
    import uart_test_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] byte_out
);

    logic [7:0] pat_q, pat_d;

    always_comb begin
        pat_d = pat_q;
        if (load) begin
            pat_d = PATTERN_SEED;
        end else if (advance) begin
`ifdef ECHO_TESTER_LFSR_EN
            pat_d = lfsr_next(pat_q);
`else
            pat_d = pat_q + 8'd1;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) pat_q <= PATTERN_SEED;
        else            pat_q <= pat_d;
    end

    assign byte_out = pat_q;

endmodule

// File: rtl/uart_echo_tester.sv
// uart_echo_tester: UART loopback initiator. Sends a byte pattern through
// uart_hs, waits for each echo, and counts passes, mismatches and timeouts.
// Pattern flavour selected by macro ECHO_TESTER_LFSR_EN (see echo_pattern_gen).
// Ports:
//   sys_clk, sys_rst_n          - clock, async active-low reset
//   start, stop                 - run control pulses (stop wins)
//   uart_rec, uart_data_out     - received byte strobe/data from uart_hs
//   uart_send, uart_data_in     - transmit request/data to uart_hs
//   running, done               - status (SEND/WAIT/GAP, DONE)
//   pass_cnt, err_cnt, timeout_cnt, last_rx - results
module uart_echo_tester
    import uart_test_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int GAP_CYCLES     = 1000,
    parameter int NUM_BYTES      = 256
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        uart_rec,
    input  logic [7:0]  uart_data_out,
    output logic        uart_send,
    output logic [7:0]  uart_data_in,
    output logic        running,
    output logic        done,
    output logic [15:0] pass_cnt,
    output logic [7:0]  err_cnt,
    output logic [7:0]  timeout_cnt,
    output logic [7:0]  last_rx
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [15:0]   NB         = 16'(NUM_BYTES);
    localparam bit            BOUNDED    = (NUM_BYTES != 0);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    data_q, data_d;
    logic [15:0]   sent_q, sent_d;
    logic [15:0]   pass_q, pass_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    to_q, to_d;
    logic [7:0]    last_rx_q, last_rx_d;
    logic          pat_load, pat_adv;
    logic [7:0]    pat_byte;

    echo_pattern_gen u_pat (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (pat_load),
        .advance   (pat_adv),
        .byte_out  (pat_byte)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        data_d    = data_q;
        sent_d    = sent_q;
        pass_d    = pass_q;
        err_d     = err_q;
        to_d      = to_q;
        last_rx_d = last_rx_q;
        pat_load  = 1'b0;
        pat_adv   = 1'b0;

        // stop overrides everything: results freeze, nothing else moves
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    // Counters are cleared on start, not while idle, so a
                    // stopped run's results stay on the display.
                    if (start) begin
                        state_d  = ST_SEND;
                        pat_load = 1'b1;
                        data_d   = PATTERN_SEED;
                        sent_d   = '0;
                        pass_d   = '0;
                        err_d    = '0;
                        to_d     = '0;
                    end
                end
                ST_SEND: begin
                    sent_d  = sent_q + 16'd1;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // A receive in the timeout cycle beats the timeout.
                    // The pattern advances on GAP entry so the new byte is
                    // ready even when GAP is a single cycle.
                    if (uart_rec) begin
                        last_rx_d = uart_data_out;
                        if (uart_data_out == data_q) pass_d = pass_q + 16'd1;
                        else if (err_q != 8'hFF)     err_d  = err_q + 8'd1;
                        gap_d   = '0;
                        pat_adv = 1'b1;
                        state_d = ST_GAP;
                    end else if (timer_q == TIMER_LAST) begin
                        if (to_q != 8'hFF) to_d = to_q + 8'd1;
                        gap_d   = '0;
                        pat_adv = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (BOUNDED && sent_q == NB) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SEND;
                            data_d  = pat_byte;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            gap_q     <= '0;
            data_q    <= '0;
            sent_q    <= '0;
            pass_q    <= '0;
            err_q     <= '0;
            to_q      <= '0;
            last_rx_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            sent_q    <= sent_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            to_q      <= to_d;
            last_rx_q <= last_rx_d;
        end
    end

    assign uart_send    = (state_q == ST_SEND);
    assign uart_data_in = data_q;
    assign running      = (state_q == ST_SEND) || (state_q == ST_WAIT) || (state_q == ST_GAP);
    assign done         = (state_q == ST_DONE);
    assign pass_cnt     = pass_q;
    assign err_cnt      = err_q;
    assign timeout_cnt  = to_q;
    assign last_rx      = last_rx_q;

endmodule

// File: tb/tb_uart_echo_tester.sv
// tb_uart_echo_tester: directed bench for uart_echo_tester with a loopback
// model that echoes each sent byte two cycles after the send.
// Honours ECHO_TESTER_LFSR_EN for the expected byte sequence.
module tb_uart_echo_tester;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        uart_rec;
    logic [7:0]  uart_data_out;
    logic        uart_send;
    logic [7:0]  uart_data_in;
    logic        running;
    logic        done;
    logic [15:0] pass_cnt;
    logic [7:0]  err_cnt;
    logic [7:0]  timeout_cnt;
    logic [7:0]  last_rx;

    logic       model_rec = 1'b0, man_rec = 1'b0;
    logic [7:0] model_data = 8'h00, man_data = 8'h00;
    logic       p0 = 1'b0, p1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    bit         echo_en = 1'b0;
    int         corrupt_idx = -1;
    int         cyc = 0;
    int         nsent = 0;
    int         send_cyc [256];
    logic [7:0] send_byte [256];
    int         checks = 0;
    int         errors = 0;

    assign uart_rec      = model_rec | man_rec;
    assign uart_data_out = man_rec ? man_data : model_data;

    uart_echo_tester #(
        .TIMEOUT_CYCLES (100),
        .GAP_CYCLES     (4),
        .NUM_BYTES      (4)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .stop          (stop),
        .uart_rec      (uart_rec),
        .uart_data_out (uart_data_out),
        .uart_send     (uart_send),
        .uart_data_in  (uart_data_in),
        .running       (running),
        .done          (done),
        .pass_cnt      (pass_cnt),
        .err_cnt       (err_cnt),
        .timeout_cnt   (timeout_cnt),
        .last_rx       (last_rx)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Loopback model: a send seen in cycle S is echoed as uart_rec in S+2.
    always @(negedge sys_clk) begin
        model_rec  = p1;
        model_data = d1;
        p1 = p0;
        d1 = d0;
        p0 = 1'b0;
        if (uart_send && nsent < 256) begin
            send_cyc[nsent]  = cyc;
            send_byte[nsent] = uart_data_in;
            p0 = echo_en;
            d0 = uart_data_in ^ ((nsent == corrupt_idx) ? 8'h80 : 8'h00);
            nsent++;
        end
    end

    function automatic logic [7:0] exp_byte(input int i);
        logic [7:0] s;
`ifdef ECHO_TESTER_LFSR_EN
        s = 8'h01;
        for (int k = 0; k < i; k++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
`else
        s = 8'(i);
`endif
        return s;
    endfunction

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_done(input int lim, input string tag);
        int k = 0;
        while (!done && k < lim) begin tick(); k++; end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_sends(input int n, input int lim, input string tag);
        int k = 0;
        while (nsent < n && k < lim) begin tick(); k++; end
        chk(tag, 32'(nsent >= n), 32'd1);
    endtask

    initial begin
        int base, s0, t0, n0, k;

        // reset state
        #2;
        chk("rst_send", 32'(uart_send), 0);
        chk("rst_data", 32'(uart_data_in), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass_cnt), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_to", 32'(timeout_cnt), 0);
        chk("rst_last_rx", 32'(last_rx), 0);
        tick(); tick();
        sys_rst_n = 1'b1;
        tick();

        // run 1: clean loopback, 4 bytes
        echo_en = 1'b1;
        base = nsent;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r1_send", 32'(uart_send), 1);
        chk("r1_data0", 32'(uart_data_in), 32'(exp_byte(0)));
        chk("r1_running", 32'(running), 1);
        tick(); tick();
        chk("r1_pass_before_echo", 32'(pass_cnt), 0);
        tick();
        chk("r1_pass_after_echo", 32'(pass_cnt), 1);
        chk("r1_last_rx0", 32'(last_rx), 32'(exp_byte(0)));
        wait_done(100, "r1_done_timeout");
        chk("r1_pass", 32'(pass_cnt), 4);
        chk("r1_err", 32'(err_cnt), 0);
        chk("r1_to", 32'(timeout_cnt), 0);
        chk("r1_nsent", 32'(nsent - base), 4);
        chk("r1_send_spacing", 32'(send_cyc[base+1] - send_cyc[base]), 7);
        for (int i = 0; i < 4; i++) chk("r1_byte_seq", 32'(send_byte[base+i]), 32'(exp_byte(i)));

        // run 2: third echo corrupted, restarted from DONE
        base = nsent;
        corrupt_idx = base + 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r2_send", 32'(uart_send), 1);
        chk("r2_pass_cleared", 32'(pass_cnt), 0);
        k = 0;
        while (err_cnt != 8'd1 && k < 60) begin tick(); k++; end
        chk("r2_err_seen", 32'(err_cnt), 1);
        chk("r2_last_rx_bad", 32'(last_rx), 32'(exp_byte(2) ^ 8'h80));
        chk("r2_pass_mid", 32'(pass_cnt), 2);
        wait_done(60, "r2_done_timeout");
        chk("r2_pass", 32'(pass_cnt), 3);
        chk("r2_err", 32'(err_cnt), 1);
        chk("r2_last_rx", 32'(last_rx), 32'(exp_byte(3)));
        corrupt_idx = -1;

        // run 3: no echo -> timeout, then stop during WAIT
        echo_en = 1'b0;
        base = nsent;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r3_send", 32'(uart_send), 1);
        s0 = cyc;
        k = 0;
        while (timeout_cnt != 8'd1 && k < 200) begin tick(); k++; end
        t0 = cyc;
        chk("r3_to_seen", 32'(timeout_cnt), 1);
        chk("r3_to_latency", 32'(t0 - s0), 101);
        chk("r3_pass_no_echo", 32'(pass_cnt), 0);
        wait_sends(base + 2, 20, "r3_second_send_timeout");
        chk("r3_next_send_gap", 32'(send_cyc[base+1] - t0), 4);
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_running", 32'(running), 0);
        chk("stop_done", 32'(done), 0);
        chk("stop_send", 32'(uart_send), 0);
        n0 = nsent;
        repeat (150) tick();
        chk("stop_no_send", 32'(nsent), 32'(n0));
        chk("stop_to_held", 32'(timeout_cnt), 1);

        // run 4: restart from IDLE, echo lands in the timeout cycle
        base = nsent;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r4_send", 32'(uart_send), 1);
        chk("r4_data0", 32'(uart_data_in), 32'(exp_byte(0)));
        chk("r4_to_cleared", 32'(timeout_cnt), 0);
        repeat (100) tick();
        man_rec = 1'b1;
        man_data = uart_data_in;
        tick();
        chk("race_pass", 32'(pass_cnt), 1);
        chk("race_to", 32'(timeout_cnt), 0);
        // now in GAP: a receive here must be ignored
        tick();
        man_rec = 1'b0;
        chk("gap_rec_pass", 32'(pass_cnt), 1);
        chk("gap_rec_err", 32'(err_cnt), 0);
        // start while running is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_pass", 32'(pass_cnt), 1);
        chk("start_ignored_running", 32'(running), 1);
        wait_sends(base + 2, 20, "r4_second_send_timeout");
        chk("r4_byte1", 32'(send_byte[base+1]), 32'(exp_byte(1)));

        // asynchronous reset mid-run
        repeat (5) tick();
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_running", 32'(running), 0);
        chk("arst_pass", 32'(pass_cnt), 0);
        chk("arst_data", 32'(uart_data_in), 0);
        n0 = nsent;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (20) tick();
        chk("arst_no_send", 32'(nsent), 32'(n0));
        chk("arst_idle", 32'(running), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_echo_tester.md
# uart_echo_tester

UART loopback initiator for board bring-up. It drives the `uart_hs` transmit side with a byte pattern and waits for each byte to come back on the receive side. Each echo is checked against the byte that was sent, and pass, mismatch and timeout counts are kept for the seg display and LEDs. It sits beside `uart_hs` in a test top and exercises any device that echoes every received byte.

## Interface
- `TIMEOUT_CYCLES`, default 500000: max `sys_clk` cycles to wait for an echo (10 ms at 50 MHz).
- `GAP_CYCLES`, default 1000: idle cycles between an echo or timeout and the next send; minimum 1.
- `NUM_BYTES`, default 256: bytes per run; 0 means run until `stop`.
- `sys_clk`  in  1  system clock; the block uses one clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- `stop`  in  1  single-cycle pulse; aborts the run and returns to IDLE.
- `uart_rec`  in  1  single-cycle strobe from `uart_hs`: a received byte is valid.
- `uart_data_out`  in  8  received byte, valid while `uart_rec` is high.
- `uart_send`  out  1  single-cycle transmit request to `uart_hs`.
- `uart_data_in`  out  8  byte to transmit; held stable from the send until the next send.
- `running`  out  1  high in SEND, WAIT and GAP.
- `done`  out  1  high in DONE.
- `pass_cnt`  out  16  number of matching echoes; wraps at 65535.
- `err_cnt`  out  8  number of mismatched echoes; saturates at 255.
- `timeout_cnt`  out  8  number of missing echoes; saturates at 255.
- `last_rx`  out  8  last byte received while in WAIT.

## Operation
- States: IDLE, SEND, WAIT, GAP, DONE.
- IDLE:
  - `start` -> SEND.
  - Clears `pass_cnt`, `err_cnt`, `timeout_cnt` and `sent_cnt`.
  - Loads the pattern seed.
- SEND:
  - Drives `uart_send`=1 for exactly one cycle, with `uart_data_in` equal to the current pattern byte.
  - Increments `sent_cnt`, then goes to WAIT with the timer at 0.
- WAIT:
  - On `uart_rec`: `last_rx` <= `uart_data_out`. If it equals `uart_data_in`, `pass_cnt`+1; otherwise `err_cnt`+1. Then GAP.
  - Otherwise the timer increments. When the timer reaches TIMEOUT_CYCLES-1: `timeout_cnt`+1, then GAP.
  - If `uart_rec` arrives in the same cycle as the timeout, the receive wins and no timeout is counted.
- GAP:
  - Counts GAP_CYCLES and advances the pattern.
  - Then goes to DONE if `NUM_BYTES`!=0 and `sent_cnt`==`NUM_BYTES`; otherwise to SEND.
- DONE: counters hold; `start` -> SEND, applying the same clears as IDLE.
- `uart_rec` outside WAIT is ignored and no counter changes. A late echo that arrives during the next WAIT is compared normally and will usually count as a mismatch.
- `stop` from any state -> IDLE next cycle. Counters hold their values, `uart_send` is not asserted, and an in-flight WAIT is abandoned without counting a timeout.
- `start` while `running` is ignored.
- `stop` and `start` in the same cycle: `stop` wins.
- `sent_cnt` is 16 bits; with `NUM_BYTES`=0 it wraps freely.

## Timing
- Reset values: state IDLE; all outputs 0, including `uart_data_in` and `last_rx`.
- `start` at cycle N -> `uart_send` high at N+1 with `uart_data_in` valid.
- `uart_rec` at cycle M in WAIT -> counter update and `last_rx` visible at M+1.
- Next `uart_send` at M+1+GAP_CYCLES.
- Timeout: a send at cycle S with no echo -> `timeout_cnt` updates at S+1+TIMEOUT_CYCLES.
- Reset asserted mid-run returns the block to IDLE immediately (asynchronous); no spurious `uart_send` follows.

## Configuration
- `ECHO_TESTER_LFSR_EN` defined: the pattern is an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded to 8'h01. It advances once per GAP; the first byte is 8'h01.
- Not defined: the pattern is an incrementing counter starting at 8'h00 and wrapping 8'hFF->8'h00.

## Structure
- Shared package `uart_test_pkg`:
  - state encoding (IDLE=0, SEND=1, WAIT=2, GAP=3, DONE=4);
  - LFSR tap mask;
  - seed constants.
- One sub-module, `echo_pattern_gen`: ports `load`, `advance`, `byte_out`. It holds the macro-selected pattern logic.
- The FSM, timers and counters stay in `uart_echo_tester`.

## Test plan
- Loopback model echoes 2 cycles after each send; NUM_BYTES=4, counter pattern; `start` -> sends 00,01,02,03 -> `pass_cnt`=4, `err_cnt`=0, `done`=1.
- Model XORs byte 02 with 8'h80 -> `err_cnt`=1, `pass_cnt`=3, `last_rx`=8'h82 after the third echo.
- No echo, TIMEOUT_CYCLES=100 -> `timeout_cnt` increments 101 cycles after each send; the next send follows GAP_CYCLES later.
- `uart_rec` in the same cycle the timer expires -> `pass_cnt`+1, `timeout_cnt` unchanged.
- `stop` during WAIT -> IDLE next cycle, no further `uart_send`, counters held. A later `start` clears them and resends 8'h00.
- With `ECHO_TESTER_LFSR_EN` and NUM_BYTES=3 -> bytes sent are 01, then the next two LFSR states; all pass.
